apb_slave_regfile: RTL and testbench

APB3/APB4 completer holding a bank of `NUM_REGS` 32-bit control/status registers. It receives one bit of the APB master's one-hot `PSELx` plus the shared `PADDR`/`PWRITE`/`PWDATA`/`PENABLE`/`PSTRB`/`PPROT` bus. It returns `PRDATA`/`PREADY`/`PSLVERR` after a programmable number of wait states. It is the downstream consumer of the APB master in the peripheral subsystem and the reference completer for master verification.

---
 rtl/apb_slave_regfile.sv | 148 ++++++++++++++
 tb/tb_apb_slave_regfile.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_regfile.sv
// APB3/APB4 completer with a bank of 32-bit registers; register 0 is a read-only ID.
// Every ACCESS phase is stretched by a fixed number of wait states before a registered response.
module apb_slave_regfile #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          ADDR_WIDTH  = 32,
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic                    PWRITE,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic [2:0]              PPROT,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int NB    = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  r_state, w_nextState;
    logic [3:0]              r_cnt, w_nextCnt;
    logic [ADDR_WIDTH-3:0]   r_addr;
    logic                    r_write;
    logic                    r_priv;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [NB-1:0]           r_strb;
    logic [DATA_WIDTH-1:0]   r_regs [NUM_REGS];

    logic                    w_latch, w_loadResp, w_commit;
    logic [ADDR_WIDTH-3:0]   w_addr;
    logic                    w_write, w_priv;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_err;
    logic [DATA_WIDTH-1:0]   w_rdata;
    logic                    w_unused;

    assign w_unused = &{1'b0, PADDR[ADDR_WIDTH-1 -: 2], PPROT[2:1]};

    // In IDLE the live bus is decoded so a zero-wait response can be loaded at the SETUP edge.
    assign w_addr  = (r_state == IDLE) ? PADDR[ADDR_WIDTH-3:0] : r_addr;
    assign w_write = (r_state == IDLE) ? PWRITE : r_write;
    assign w_priv  = (r_state == IDLE) ? PPROT[0] : r_priv;
    assign w_idx   = w_addr[2+IDX_W-1:2];

    assign w_err = (|w_addr[1:0])
                 | (|(w_addr >> (2 + IDX_W)))
                 | (w_write && (w_idx == '0))
                 | (w_idx[IDX_W-1] && !w_priv);

    assign w_rdata = (w_idx == '0) ? ID_VALUE : r_regs[w_idx];

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_latch     = 1'b0;
        w_loadResp  = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    w_latch = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        w_nextState = RESP;
                        w_loadResp  = 1'b1;
                    end else begin
                        w_nextState = WAIT;
                        w_nextCnt   = 4'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                if (!PSEL) begin
                    w_nextState = IDLE;
                    w_nextCnt   = '0;
                end else if (r_cnt == 4'd1) begin
                    w_nextState = RESP;
                    w_nextCnt   = '0;
                    w_loadResp  = 1'b1;
                end else begin
                    w_nextCnt = r_cnt - 4'd1;
                end
            end
            RESP: begin
                w_nextState = IDLE;
                w_commit    = PSEL && PENABLE && r_write && !w_err;
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_priv  <= 1'b0;
            r_wdata <= '0;
            r_strb  <= '0;
        end else if (w_latch) begin
            r_addr  <= PADDR[ADDR_WIDTH-3:0];
            r_write <= PWRITE;
            r_priv  <= PPROT[0];
            r_wdata <= PWDATA;
            r_strb  <= PSTRB;
        end
    end

    // Outputs are only non-zero for the single RESP cycle.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PRDATA  <= '0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
        end else begin
            PREADY  <= w_loadResp;
            PSLVERR <= w_loadResp && w_err;
            PRDATA  <= (w_loadResp && !w_write && !w_err) ? w_rdata : '0;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_commit) begin
            for (int k = 0; k < NB; k++)
                if (r_strb[k]) r_regs[w_idx][8*k +: 8] <= r_wdata[8*k +: 8];
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench for apb_slave_regfile: one instance with 2 wait states, one with none.
// Expected responses are queued when a transfer is issued and popped when PREADY rises.
module tb_apb_slave_regfile;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        psel2 = 1'b0, psel0 = 1'b0;
    logic        PENABLE = 1'b0;
    logic [31:0] PADDR = '0;
    logic        PWRITE = 1'b0;
    logic [31:0] PWDATA = '0;
    logic [3:0]  PSTRB = '0;
    logic [2:0]  PPROT = '0;
    logic [31:0] prdata2, prdata0;
    logic        pready2, pready0, pslverr2, pslverr0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          waits;
    } exp_t;
    exp_t sbq[$];

    logic [31:0] model [8];

    always #5 PCLK = ~PCLK;

    apb_slave_regfile #(.WAIT_CYCLES(2)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel2), .PENABLE(PENABLE),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PRDATA(prdata2), .PREADY(pready2), .PSLVERR(pslverr2)
    );

    apb_slave_regfile #(.WAIT_CYCLES(0)) dut0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel0), .PENABLE(PENABLE),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
    );

    task automatic busIdle();
        @(negedge PCLK);
        psel2 = 1'b0;
        psel0 = 1'b0;
        PENABLE = 1'b0;
    endtask

    // Full transfer; the bus is scrambled during ACCESS to prove SETUP values are latched.
    task automatic apbXfer(input bit fast, input logic [31:0] addr, input bit wr,
                           input logic [31:0] wdata, input logic [3:0] strb,
                           input logic [2:0] prot, input logic [31:0] expData,
                           input bit expErr, input string name);
        exp_t e;
        int n;
        logic rdy, err;
        logic [31:0] data;
        @(negedge PCLK);
        psel0 = fast;
        psel2 = !fast;
        PENABLE = 1'b0;
        PADDR = addr;
        PWRITE = wr;
        PWDATA = wdata;
        PSTRB = strb;
        PPROT = prot;
        e.data = expData;
        e.err = expErr;
        e.waits = fast ? 0 : 2;
        sbq.push_back(e);
        @(negedge PCLK);
        PENABLE = 1'b1;
        PADDR = addr ^ 32'h0000_0004;
        PWDATA = ~wdata;
        PSTRB = ~strb;
        n = 0;
        rdy = fast ? pready0 : pready2;
        while (rdy !== 1'b1 && n < 20) begin
            @(negedge PCLK);
            n++;
            rdy = fast ? pready0 : pready2;
        end
        e = sbq.pop_front();
        data = fast ? prdata0 : prdata2;
        err = fast ? pslverr0 : pslverr2;
        checks++;
        if (n !== e.waits) begin
            errors++;
            $display("[TB] FAIL %s waits: got %0d expected %0d", name, n, e.waits);
        end
        checks++;
        if (data !== e.data) begin
            errors++;
            $display("[TB] FAIL %s PRDATA: got %h expected %h", name, data, e.data);
        end
        checks++;
        if (err !== e.err) begin
            errors++;
            $display("[TB] FAIL %s PSLVERR: got %b expected %b", name, err, e.err);
        end
    endtask

    task automatic test_reset();
        @(negedge PCLK);
        checks++;
        if ({prdata2, pready2, pslverr2, prdata0, pready0, pslverr0} !== '0) begin
            errors++;
            $display("[TB] FAIL reset outputs: got %h/%b/%b %h/%b/%b expected all zero",
                     prdata2, pready2, pslverr2, prdata0, pready0, pslverr0);
        end
        apbXfer(0, 32'h8, 0, 0, 4'hF, 3'b001, 32'h0, 0, "reset_reg2");
        busIdle();
    endtask

    task automatic test_id_read();
        apbXfer(0, 32'h0, 0, 0, 4'hF, 3'b000, 32'hA9B0_0001, 0, "id_read");
        busIdle();
    endtask

    task automatic test_strobe_write();
        apbXfer(0, 32'h4, 1, 32'hDEADBEEF, 4'b1111, 3'b001, 32'h0, 0, "wr_full");
        apbXfer(0, 32'h4, 1, 32'h00000011, 4'b0001, 3'b001, 32'h0, 0, "wr_byte0");
        apbXfer(0, 32'h4, 0, 0, 4'hF, 3'b001, 32'hDEADBE11, 0, "rd_merged");
        apbXfer(0, 32'h4, 1, 32'h12345678, 4'b0000, 3'b001, 32'h0, 0, "wr_nostrb");
        apbXfer(0, 32'h4, 0, 0, 4'hF, 3'b001, 32'hDEADBE11, 0, "rd_nostrb");
        busIdle();
    endtask

    task automatic test_errors();
        apbXfer(0, 32'h0, 1, 32'h1111_1111, 4'hF, 3'b001, 32'h0, 1, "wr_id");
        apbXfer(0, 32'h0, 0, 0, 4'hF, 3'b001, 32'hA9B0_0001, 0, "rd_id_after");
        apbXfer(0, 32'h2, 0, 0, 4'hF, 3'b001, 32'h0, 1, "rd_misaligned");
        apbXfer(0, 32'h40, 0, 0, 4'hF, 3'b001, 32'h0, 1, "rd_range");
        apbXfer(0, 32'h6, 1, 32'hFFFF_FFFF, 4'hF, 3'b001, 32'h0, 1, "wr_misaligned");
        apbXfer(0, 32'h4, 0, 0, 4'hF, 3'b001, 32'hDEADBE11, 0, "rd_after_misal");
        apbXfer(0, 32'h20, 1, 32'hBAD0_BAD0, 4'hF, 3'b000, 32'h0, 1, "wr_prot");
        apbXfer(0, 32'h20, 0, 0, 4'hF, 3'b001, 32'h0, 0, "rd_prot_old");
        apbXfer(0, 32'h3C, 1, 32'h0000_CAFE, 4'hF, 3'b001, 32'h0, 0, "wr_priv_top");
        apbXfer(0, 32'h3C, 0, 0, 4'hF, 3'b000, 32'h0, 1, "rd_unpriv_top");
        apbXfer(0, 32'h3C, 0, 0, 4'hF, 3'b001, 32'h0000_CAFE, 0, "rd_priv_top");
        busIdle();
    endtask

    task automatic test_back_to_back();
        apbXfer(1, 32'h8, 1, 32'h5, 4'hF, 3'b001, 32'h0, 0, "b2b_wr");
        apbXfer(1, 32'h8, 0, 0, 4'hF, 3'b001, 32'h5, 0, "b2b_rd");
        apbXfer(1, 32'h40, 0, 0, 4'hF, 3'b001, 32'h0, 1, "b2b_range");
        apbXfer(1, 32'h0, 0, 0, 4'hF, 3'b000, 32'hA9B0_0001, 0, "b2b_id");
    endtask

    task automatic test_random();
        int idx;
        logic [31:0] d;
        logic [3:0] s;
        for (int i = 0; i < 8; i++) model[i] = '0;
        model[2] = 32'h5;
        for (int i = 0; i < 10; i++) begin
            idx = $urandom_range(1, 7);
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            for (int k = 0; k < 4; k++)
                if (s[k]) model[idx][8*k +: 8] = d[8*k +: 8];
            apbXfer(1, 32'(idx * 4), 1, d, s, 3'b001, 32'h0, 0, "rnd_wr");
            apbXfer(1, 32'(idx * 4), 0, 0, 4'hF, 3'b001, model[idx], 0, "rnd_rd");
        end
        busIdle();
    endtask

    task automatic test_penable_idle();
        int highs = 0;
        @(negedge PCLK);
        psel2 = 1'b1;
        PENABLE = 1'b1;
        PADDR = 32'h0;
        PWRITE = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge PCLK);
            if (pready2 !== 1'b0) highs++;
        end
        checks++;
        if (highs != 0) begin
            errors++;
            $display("[TB] FAIL penable_idle: got %0d PREADY cycles expected 0", highs);
        end
        busIdle();
    endtask

    task automatic test_abort();
        int highs = 0;
        apbXfer(0, 32'hC, 1, 32'h0000_1234, 4'hF, 3'b001, 32'h0, 0, "abort_prep");
        busIdle();
        @(negedge PCLK);
        psel2 = 1'b1;
        PENABLE = 1'b0;
        PADDR = 32'hC;
        PWRITE = 1'b1;
        PWDATA = 32'hFFFF_FFFF;
        PSTRB = 4'hF;
        PPROT = 3'b001;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        psel2 = 1'b0;
        PENABLE = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (pready2 !== 1'b0) highs++;
            @(negedge PCLK);
        end
        checks++;
        if (highs != 0) begin
            errors++;
            $display("[TB] FAIL abort_pready: got %0d PREADY cycles expected 0", highs);
        end
        apbXfer(0, 32'hC, 0, 0, 4'hF, 3'b001, 32'h0000_1234, 0, "abort_rd");
        busIdle();
    endtask

    task automatic test_reset_mid();
        int highs = 0;
        @(negedge PCLK);
        psel2 = 1'b1;
        PENABLE = 1'b0;
        PADDR = 32'hC;
        PWRITE = 1'b1;
        PWDATA = 32'h0000_BEEF;
        PSTRB = 4'hF;
        PPROT = 3'b001;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        PRESETn = 1'b0;
        #1;
        if (pready2 !== 1'b0) highs++;
        @(negedge PCLK);
        PRESETn = 1'b1;
        psel2 = 1'b0;
        PENABLE = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (pready2 !== 1'b0) highs++;
            @(negedge PCLK);
        end
        checks++;
        if (highs != 0) begin
            errors++;
            $display("[TB] FAIL reset_mid_pready: got %0d PREADY cycles expected 0", highs);
        end
        apbXfer(0, 32'hC, 0, 0, 4'hF, 3'b001, 32'h0, 0, "reset_mid_rdC");
        apbXfer(0, 32'h4, 0, 0, 4'hF, 3'b001, 32'h0, 0, "reset_mid_rd4");
        busIdle();
    endtask

    initial begin
        repeat (3) @(negedge PCLK);
        PRESETn = 1'b1;
        test_reset();
        test_id_read();
        test_strobe_write();
        test_errors();
        test_back_to_back();
        test_random();
        test_penable_idle();
        test_abort();
        test_reset_mid();
        repeat (2) @(negedge PCLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
